// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  // Sequential successor address; wraps modulo 2^32 with no carry out.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit_skid.sv
// Decode-facing output register plus one skid entry.
// Flush empties both entries and takes priority over any consume or load.
module if_skid_buffer
  import if_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [XLEN-1:0]   out_pc
);

  logic              out_valid_r;
  logic [INST_W-1:0] out_inst_r;
  logic [XLEN-1:0]   out_pc_r;
  logic              skid_valid_r;
  logic [INST_W-1:0] skid_inst_r;
  logic [XLEN-1:0]   skid_pc_r;
  logic              slot_free_s;

  assign slot_free_s = !out_valid_r || out_ready;
  assign in_ready    = !skid_valid_r;
  assign out_valid   = out_valid_r;
  assign out_inst    = out_inst_r;
  assign out_pc      = out_pc_r;

  // Output/skid entry update: flush, then drain skid, then accept new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_inst_r   <= 32'h0000_0000;
      out_pc_r     <= 32'h0000_0000;
      skid_valid_r <= 1'b0;
      skid_inst_r  <= 32'h0000_0000;
      skid_pc_r    <= 32'h0000_0000;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (skid_valid_r) begin
      if (out_ready) begin
        out_inst_r   <= skid_inst_r;
        out_pc_r     <= skid_pc_r;
        skid_valid_r <= 1'b0;
      end
    end else if (in_valid) begin
      if (slot_free_s) begin
        out_valid_r <= 1'b1;
        out_inst_r  <= in_inst;
        out_pc_r    <= in_pc;
      end else begin
        skid_valid_r <= 1'b1;
        skid_inst_r  <= in_inst;
        skid_pc_r    <= in_pc;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding fetch at a
// time and hands fetched words to decode, discarding stale ones on redirect.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              im_req_valid,
  input  logic              im_req_ready,
  output logic [XLEN-1:0]   im_addr,
  input  logic              im_rsp_valid,
  input  logic [INST_W-1:0] im_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   if_pc4
);

  fetch_state_e    state_r, state_nxt_s;
  logic [XLEN-1:0] pc_r, pc_nxt_s, fetch_pc_r;
  logic            drop_r, drop_nxt_s;
  logic            out_valid_s, skid_free_s, slot_free_s;
  logic            req_valid_s, req_fire_s, flush_s, push_s;

  assign slot_free_s = !out_valid_s || if_ready;
  assign req_valid_s = (state_r == REQ) && slot_free_s && skid_free_s;
  assign req_fire_s  = req_valid_s && im_req_ready;
  assign flush_s     = redirect && (state_r != IDLE);
  assign push_s      = (state_r == WAIT) && im_rsp_valid && !drop_r && !flush_s;

  assign im_req_valid = req_valid_s;
  assign im_addr      = pc_r;
  assign if_valid     = out_valid_s;

  // Next-state, next-pc and stale-response tracking; redirect overrides all.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    drop_nxt_s  = drop_r;
    if (flush_s) begin
      pc_nxt_s = redirect_pc;
      if (((state_r == WAIT) && !im_rsp_valid) || req_fire_s) begin
        drop_nxt_s  = 1'b1;
        state_nxt_s = WAIT;
      end else begin
        drop_nxt_s  = 1'b0;
        state_nxt_s = REQ;
      end
    end else begin
      case (state_r)
        IDLE: state_nxt_s = REQ;
        REQ: begin
          if (req_fire_s) state_nxt_s = WAIT;
          else            state_nxt_s = REQ;
        end
        WAIT: begin
          if (!im_rsp_valid) begin
            state_nxt_s = WAIT;
          end else if (drop_r) begin
            // Only one request can be in flight, so nothing new is pending.
            drop_nxt_s  = 1'b0;
            state_nxt_s = REQ;
          end else begin
            pc_nxt_s = pc_plus4(fetch_pc_r);
            if (slot_free_s) state_nxt_s = REQ;
            else             state_nxt_s = HOLD;
          end
        end
        HOLD: begin
          if (if_ready) state_nxt_s = REQ;
          else          state_nxt_s = HOLD;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM, architectural pc, address of the in-flight fetch and drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      fetch_pc_r <= RESET_PC;
      drop_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      drop_r  <= drop_nxt_s;
      if (req_fire_s) fetch_pc_r <= pc_r;
    end
  end

  if_skid_buffer u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s),
    .in_valid  (push_s),
    .in_ready  (skid_free_s),
    .in_inst   (im_rsp_data),
    .in_pc     (fetch_pc_r),
    .out_valid (out_valid_s),
    .out_ready (if_ready),
    .out_inst  (if_inst),
    .out_pc    (if_pc)
  );

  assign if_pc4 = pc_plus4(if_pc);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a behavioural memory plus an in-order program-stream
// scoreboard (each consumed word must be the next sequential or redirect PC).
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, redirect, im_req_ready, im_rsp_valid, if_ready;
  logic [31:0] redirect_pc, im_rsp_data;
  logic        im_req_valid, if_valid;
  logic [31:0] im_addr, if_inst, if_pc, if_pc4;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model and scoreboard state
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt  = 0;
  int          lat_lo = 0, lat_hi = 0, rdy_pct = 100;
  logic [31:0] exp_pc = 32'h0000_0100;
  logic [31:0] acc_q[$];
  int          n_cons = 0, n_acc = 0, n_rsp = 0;
  logic        s_req_valid;
  logic [31:0] s_addr;

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk (clk), .rst_n (rst_n), .redirect (redirect), .redirect_pc (redirect_pc),
    .im_req_valid (im_req_valid), .im_req_ready (im_req_ready), .im_addr (im_addr),
    .im_rsp_valid (im_rsp_valid), .im_rsp_data (im_rsp_data),
    .if_valid (if_valid), .if_ready (if_ready), .if_inst (if_inst),
    .if_pc (if_pc), .if_pc4 (if_pc4)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, {31'd0, im_req_valid}, 32'd0);
    chk({tag, "_if_valid"},  {31'd0, if_valid},     32'd0);
    chk({tag, "_if_pc"},     if_pc,                 32'h0000_0000);
    chk({tag, "_if_inst"},   if_inst,               32'h0000_0000);
    chk({tag, "_if_pc4"},    if_pc4,                32'h0000_0004);
    chk({tag, "_im_addr"},   im_addr,               32'h0000_0100);
  endtask

  // One clock: drive inputs at negedge, then predict what the next posedge does.
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic resp;
    @(negedge clk);
    if_ready     = rdy;
    redirect     = redir;
    redirect_pc  = rpc;
    resp         = mem_busy && (mem_cnt == 0);
    im_rsp_valid = resp;
    im_rsp_data  = resp ? inst_of(mem_addr) : $urandom;
    im_req_ready = ($urandom_range(99) < rdy_pct);
    #1;
    s_req_valid = im_req_valid;
    s_addr      = im_addr;
    if (mem_busy) chk("no_req_while_outstanding", {31'd0, s_req_valid}, 32'd0);
    if (if_valid && rdy && !redir) begin
      chk("if_pc",   if_pc,   exp_pc);
      chk("if_inst", if_inst, inst_of(exp_pc));
      chk("if_pc4",  if_pc4,  exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      n_cons++;
    end
    if (redir) exp_pc = rpc;
    if (resp) begin
      mem_busy = 1'b0;
      n_rsp++;
    end else if (mem_busy) begin
      mem_cnt--;
    end
    if (s_req_valid && im_req_ready) begin
      mem_busy = 1'b1;
      mem_addr = s_addr;
      mem_cnt  = $urandom_range(lat_hi, lat_lo);
      acc_q.push_back(s_addr);
      n_acc++;
    end
  endtask

  task automatic wait_consume(input string tag, input int n, input int budget);
    int target;
    int k;
    target = n_cons + n;
    k = 0;
    while (n_cons < target && k < budget) begin
      tick(1'b1, 1'b0, 32'h0);
      k++;
    end
    chk(tag, {31'd0, (n_cons >= target)}, 32'd1);
  endtask

  int          acc0, rsp0, mark, idx, k, cons0;
  logic        busy0;
  logic [31:0] rpc;

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; im_req_ready = 1'b0;
    im_rsp_valid = 1'b0; im_rsp_data = 32'h0; if_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait memory, decode always ready: one instruction every two cycles
    tick(1'b1, 1'b0, 32'h0);
    chk("first_req_valid", {31'd0, s_req_valid}, 32'd1);
    chk("first_req_addr",  s_addr, 32'h0000_0100);
    repeat (11) tick(1'b1, 1'b0, 32'h0);
    chk("seq_addr0", (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD_BEEF, 32'h0000_0100);
    chk("seq_addr1", (acc_q.size() > 1) ? acc_q[1] : 32'hDEAD_BEEF, 32'h0000_0104);
    chk("seq_addr2", (acc_q.size() > 2) ? acc_q[2] : 32'hDEAD_BEEF, 32'h0000_0108);
    chk("throughput_consumed", n_cons, 32'd5);
    chk("throughput_requests", n_acc,  32'd6);

    // Decode back-pressure: in-flight word is kept, no new request issued
    tick(1'b1, 1'b0, 32'h0);
    busy0 = mem_busy; acc0 = n_acc; rsp0 = n_rsp;
    repeat (5) tick(1'b0, 1'b0, 32'h0);
    chk("stall_no_new_req", n_acc - acc0, 32'd0);
    chk("stall_one_rsp",    n_rsp - rsp0, busy0 ? 32'd1 : 32'd0);
    chk("stall_if_valid",   {31'd0, if_valid}, 32'd1);
    wait_consume("stall_drain", 3, 40);

    // Redirect while waiting: stale response dropped, target fetched after it
    lat_lo = 2; lat_hi = 2;
    k = 0;
    while (!(mem_busy && mem_cnt >= 1) && k < 50) begin
      tick(1'b1, 1'b0, 32'h0);
      k++;
    end
    chk("wait_redirect_setup", {31'd0, mem_busy}, 32'd1);
    tick(1'b1, 1'b1, 32'h0000_2000);
    mark = acc_q.size();
    tick(1'b1, 1'b0, 32'h0);
    chk("drop_pending_no_req", {31'd0, s_req_valid}, 32'd0);
    wait_consume("wait_redirect_consume", 2, 60);
    chk("wait_redirect_addr", (acc_q.size() > mark) ? acc_q[mark] : 32'hDEAD_BEEF, 32'h0000_2000);

    // Redirect coinciding with the response: nothing pending afterwards
    lat_lo = 0; lat_hi = 0;
    k = 0;
    while (!(mem_busy && mem_cnt == 0) && k < 50) begin
      tick(1'b1, 1'b0, 32'h0);
      k++;
    end
    tick(1'b1, 1'b1, 32'h0000_3000);
    tick(1'b1, 1'b0, 32'h0);
    chk("rsp_redirect_req_valid", {31'd0, s_req_valid}, 32'd1);
    chk("rsp_redirect_addr",      s_addr, 32'h0000_3000);
    wait_consume("rsp_redirect_consume", 2, 40);

    // PC wrap-around at the top of the address space
    tick(1'b1, 1'b1, 32'hFFFF_FFF8);
    wait_consume("wrap_consume", 3, 60);
    idx = -1;
    foreach (acc_q[i]) if (acc_q[i] == 32'hFFFF_FFFC) idx = i;
    chk("wrap_next_addr", (idx >= 0 && idx + 1 < acc_q.size()) ? acc_q[idx + 1] : 32'hDEAD_BEEF,
        32'h0000_0000);

    // Reset while a fetch is outstanding; its late response must be ignored
    lat_lo = 2; lat_hi = 2;
    k = 0;
    while (!mem_busy && k < 50) begin
      tick(1'b1, 1'b0, 32'h0);
      k++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset("midreset");
    @(negedge clk);
    im_rsp_valid = 1'b1;
    im_rsp_data  = inst_of(mem_addr);
    #1 chk("midreset_rsp_if_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    mem_busy = 1'b0;
    exp_pc   = 32'h0000_0100;
    mark     = acc_q.size();
    wait_consume("midreset_restart", 2, 40);
    chk("midreset_first_addr", (acc_q.size() > mark) ? acc_q[mark] : 32'hDEAD_BEEF, 32'h0000_0100);

    // Randomised traffic: memory stalls, variable latency, back-pressure, redirects
    lat_lo = 0; lat_hi = 3; rdy_pct = 70;
    cons0 = n_cons;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(99) < 4) begin
        case ($urandom_range(2))
          0:       rpc = $urandom & 32'hFFFF_FFFC;
          1:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
          default: rpc = $urandom;
        endcase
        tick($urandom_range(99) < 75, 1'b1, rpc);
      end else begin
        tick($urandom_range(99) < 75, 1'b0, 32'h0);
      end
    end
    chk("random_progress", {31'd0, (n_cons - cons0 > 40)}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
